// File: rtl/datamem_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | Module   : datamem_pkg                                          |
// | Purpose  : Shared types and constants for the data-memory       |
// |            two-port arbiter.                                    |
// | Revision : 1.0  initial release                                 |
// +-----------------------------------------------------------------+
package datamem_pkg;

   // Default number of legal word addresses behind the arbiter
   localparam int MEM_DEPTH_DEF = 1024;

   // Arbiter transaction phases
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   // Requester index: 0 = port 0, 1 = port 1
   typedef logic port_idx_t;

endpackage
`default_nettype wire

// File: rtl/datamem_arbiter_rr_arb2.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | Module   : rr_arb2                                              |
// | Purpose  : Two-way winner select. A tie goes to the port that   |
// |            did not win last time when DATAMEM_ARB_RR_EN is      |
// |            defined, otherwise port 0 always wins a tie.         |
// | Revision : 1.0  initial release                                 |
// +-----------------------------------------------------------------+
module rr_arb2
   import datamem_pkg::*;
(
   input  logic      req0,
   input  logic      req1,
   input  logic      last_grant,
   output port_idx_t winner
);

`ifndef DATAMEM_ARB_RR_EN
   // Fixed priority has no use for grant history
   logic unused_last_grant;
   assign unused_last_grant = last_grant;
`endif

   // Pick the winner; a lone requester always wins
   always_comb begin
      winner = 1'b0;
      if (req0 && req1) begin
`ifdef DATAMEM_ARB_RR_EN
         winner = ~last_grant;
`else
         winner = 1'b0;
`endif
      end else if (req1) begin
         winner = 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/datamem_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | Module   : datamem_arbiter                                      |
// | Purpose  : Shares one registered-read data memory between two   |
// |            requesters. Each transaction takes IDLE->ISSUE->RESP.|
// |            Define DATAMEM_ARB_RR_EN for round-robin tie-break;  |
// |            default build is fixed priority to port 0.           |
// | Revision : 1.0  initial release                                 |
// +-----------------------------------------------------------------+
module datamem_arbiter
   import datamem_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MEM_DEPTH = MEM_DEPTH_DEF
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              done0,
   output logic              done1,
   output logic              err0,
   output logic              err1,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_memwrite,
   output logic              mem_memread,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(MEM_DEPTH);

   state_t            state;
   state_t            state_nxt;
   port_idx_t         winner;
   port_idx_t         sel;
   logic              lat_we;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic              last_grant;
   logic              any_req;
   logic              start;
   logic              oor;

   assign any_req = req0 | req1;
   assign start   = (state == IDLE) && any_req;
   assign oor     = ({1'b0, lat_addr} >= DEPTH_EXT);

`ifdef DATAMEM_ARB_RR_EN
   // Remember who won most recently; reset value makes port 0 win the first tie
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= 1'b1;
      end else if (start) begin
         last_grant <= winner;
      end
   end
`else
   assign last_grant = 1'b1;
`endif

   rr_arb2 u_rr_arb2 (
      .req0       (req0),
      .req1       (req1),
      .last_grant (last_grant),
      .winner     (winner)
   );

   // Transaction phase register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Capture the winning request; held values also keep the memory bus stable
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel       <= 1'b0;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
      end else if (start) begin
         sel       <= winner;
         lat_we    <= winner ? we1    : we0;
         lat_addr  <= winner ? addr1  : addr0;
         lat_wdata <= winner ? wdata1 : wdata0;
      end
   end

   assign mem_addr  = lat_addr;
   assign mem_wdata = lat_wdata;

   // Next phase plus per-phase grant, strobe and completion outputs
   always_comb begin
      state_nxt    = state;
      gnt0         = 1'b0;
      gnt1         = 1'b0;
      done0        = 1'b0;
      done1        = 1'b0;
      err0         = 1'b0;
      err1         = 1'b0;
      mem_memwrite = 1'b0;
      mem_memread  = 1'b0;
      rdata        = '0;
      case (state)
         IDLE: begin
            if (any_req) state_nxt = ISSUE;
         end
         ISSUE: begin
            state_nxt    = RESP;
            gnt0         = (sel == 1'b0);
            gnt1         = (sel == 1'b1);
            mem_memwrite = lat_we  && !oor;
            mem_memread  = !lat_we && !oor;
         end
         RESP: begin
            state_nxt = IDLE;
            done0     = (sel == 1'b0);
            done1     = (sel == 1'b1);
            err0      = (sel == 1'b0) && oor;
            err1      = (sel == 1'b1) && oor;
            rdata     = mem_rdata;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_datamem_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | Module   : tb_datamem_arbiter                                   |
// | Purpose  : Self-checking bench for datamem_arbiter with a       |
// |            behavioural memory and transaction-level reference.  |
// |            Honours DATAMEM_ARB_RR_EN like the design.           |
// | Revision : 1.0  initial release                                 |
// +-----------------------------------------------------------------+
module tb_datamem_arbiter;

   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int DEPTH = 1024;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req0, req1, we0, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic          gnt0, gnt1, done0, done1, err0, err1;
   logic [DW-1:0] rdata;
   logic          mem_memwrite, mem_memread;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   datamem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
      .err0(err0), .err1(err1), .rdata(rdata),
      .mem_memwrite(mem_memwrite), .mem_memread(mem_memread),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Behavioural data memory: synchronous write, registered read
   logic [DW-1:0] mem_env [0:DEPTH-1];
   always @(posedge clk) begin
      if (mem_memwrite) mem_env[mem_addr[9:0]] <= mem_wdata;
      if (mem_memread)  mem_rdata <= mem_env[mem_addr[9:0]];
   end

   // Reference model state
   logic [DW-1:0] mem_ref [0:DEPTH-1];
   int            cyc;
   int            issue_cyc, done_cyc, next_free;
   int            lg;
   int            p_w;
   logic          p_we, p_oor;
   logic [AW-1:0] p_addr;
   logic [DW-1:0] p_wdata;
   logic          obs_done [2];
   logic [DW-1:0] last_rdata;
   logic          last_err;
   int            gq[$];
   logic          active [2];

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
   endtask

   task automatic model_reset();
      issue_cyc = -1;
      done_cyc  = -1;
      next_free = 0;
      lg        = 1;
   endtask

   // Decide whether the coming edge starts a transaction, from the arbitration rules
   task automatic model_decide();
      int w;
      if (rst_n && cyc >= next_free && (req0 || req1)) begin
         if (req0 && req1) begin
`ifdef DATAMEM_ARB_RR_EN
            w = (lg == 0) ? 1 : 0;
`else
            w = 0;
`endif
         end else begin
            w = req1 ? 1 : 0;
         end
         lg        = w;
         p_w       = w;
         p_we      = w ? we1    : we0;
         p_addr    = w ? addr1  : addr0;
         p_wdata   = w ? wdata1 : wdata0;
         p_oor     = (p_addr >= 32'(DEPTH));
         issue_cyc = cyc + 1;
         done_cyc  = cyc + 2;
         next_free = cyc + 3;
      end
   endtask

   // Compare every output against what this cycle should show
   task automatic check_cycle();
      logic is_iss, is_done, e_d0, e_d1;
      is_iss  = (cyc == issue_cyc);
      is_done = (cyc == done_cyc);
      e_d0    = is_done && (p_w == 0);
      e_d1    = is_done && (p_w == 1);
      check_eq("gnt0", gnt0, is_iss && (p_w == 0));
      check_eq("gnt1", gnt1, is_iss && (p_w == 1));
      check_eq("memwrite", mem_memwrite, is_iss && p_we && !p_oor);
      check_eq("memread", mem_memread, is_iss && !p_we && !p_oor);
      check_eq("done0", done0, e_d0);
      check_eq("done1", done1, e_d1);
      check_eq("err0", err0, e_d0 && p_oor);
      check_eq("err1", err1, e_d1 && p_oor);
      if (is_iss) check_eq("mem_addr", mem_addr, p_addr);
      if (is_iss && p_we) check_eq("mem_wdata", mem_wdata, p_wdata);
      if (is_done && !p_we && !p_oor) check_eq("rdata", rdata, mem_ref[p_addr[9:0]]);
      if (is_done && p_we && !p_oor) mem_ref[p_addr[9:0]] = p_wdata;
      obs_done[0] = done0;
      obs_done[1] = done1;
      if (gnt0) gq.push_back(0);
      if (gnt1) gq.push_back(1);
      if (done0 || done1) begin
         last_rdata = rdata;
         last_err   = err0 | err1;
      end
   endtask

   task automatic tick();
      model_decide();
      @(posedge clk);
      cyc++;
      @(negedge clk);
      check_cycle();
   endtask

   task automatic drive_port(input int k, input logic r, input logic w,
                             input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (k == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
      else        begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
   endtask

   task automatic run_until_done(input int k, input string tag);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         tick();
         got = obs_done[k];
      end
      if (!got) check_eq({tag, " timeout"}, 0, 1);
   endtask

   function automatic logic [AW-1:0] rand_addr();
      int r;
      r = $urandom_range(0, 9);
      if (r == 0)      return 32'(DEPTH);
      else if (r == 1) return 32'(DEPTH - 1);
      else if (r == 2) return $urandom | 32'h0000_8000;
      else             return 32'($urandom_range(0, 31));
   endfunction

   initial begin
      int diffs;
      rst_n = 1'b0;
      drive_port(0, 1'b0, 1'b0, '0, '0);
      drive_port(1, 1'b0, 1'b0, '0, '0);
      for (int i = 0; i < DEPTH; i++) begin
         mem_env[i] = '0;
         mem_ref[i] = '0;
      end
      cyc = 0;
      obs_done[0] = 1'b0; obs_done[1] = 1'b0;
      active[0] = 1'b0; active[1] = 1'b0;
      model_reset();

      // Reset state
      @(negedge clk);
      check_eq("rst gnt", {gnt0, gnt1}, 2'b00);
      check_eq("rst done", {done0, done1, err0, err1}, 4'b0000);
      check_eq("rst strobes", {mem_memwrite, mem_memread}, 2'b00);
      check_eq("rst mem_addr", mem_addr, 0);
      check_eq("rst mem_wdata", mem_wdata, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Port 0 write, then port 1 read of the same word
      drive_port(0, 1'b1, 1'b1, 32'd5, 32'hDEAD_BEEF);
      run_until_done(0, "wr5");
      check_eq("wr5 err", last_err, 1'b0);
      drive_port(0, 1'b0, 1'b0, 32'd5, 32'hDEAD_BEEF);
      drive_port(1, 1'b1, 1'b0, 32'd5, 32'h0);
      run_until_done(1, "rd5");
      check_eq("rd5 rdata", last_rdata, 32'hDEAD_BEEF);
      drive_port(1, 1'b0, 1'b0, 32'd5, 32'h0);

      // Both ports requesting back to back
      tick();
      gq.delete();
      drive_port(0, 1'b1, 1'b0, 32'd5, 32'h0);
      drive_port(1, 1'b1, 1'b0, 32'd6, 32'h0);
      for (int i = 0; i < 12; i++) tick();
      drive_port(0, 1'b0, 1'b0, 32'd5, 32'h0);
      drive_port(1, 1'b0, 1'b0, 32'd6, 32'h0);
      check_eq("tie grants", gq.size(), 4);
      if (gq.size() >= 4) begin
`ifdef DATAMEM_ARB_RR_EN
         check_eq("tie order", {gq[0][0], gq[1][0], gq[2][0], gq[3][0]}, 4'b0101);
`else
         check_eq("tie order", {gq[0][0], gq[1][0], gq[2][0], gq[3][0]}, 4'b0000);
`endif
      end
      tick(); tick();

      // Out-of-range write
      drive_port(0, 1'b1, 1'b1, 32'(DEPTH), 32'h1234_5678);
      run_until_done(0, "oor");
      check_eq("oor err", last_err, 1'b1);
      drive_port(0, 1'b0, 1'b0, 32'(DEPTH), 32'h1234_5678);
      tick();

      // Reset asserted mid-ISSUE aborts the write; the held request then completes
      drive_port(0, 1'b1, 1'b1, 32'd7, 32'hCAFE_0007);
      tick();
      check_eq("pre-abort write", mem_memwrite, 1'b1);
      rst_n = 1'b0;
      #1;
      check_eq("abort strobes", {mem_memwrite, mem_memread, gnt0, gnt1}, 4'b0000);
      check_eq("abort mem_addr", mem_addr, 0);
      model_reset();
      tick();
      rst_n = 1'b1;
      run_until_done(0, "post-abort");
      check_eq("post-abort err", last_err, 1'b0);
      drive_port(0, 1'b0, 1'b0, 32'd7, 32'h0);

      // Random traffic from both ports
      for (int c = 0; c < 400; c++) begin
         for (int k = 0; k < 2; k++) begin
            if (active[k] && obs_done[k]) active[k] = 1'b0;
            if (!active[k]) begin
               if ($urandom_range(0, 2) != 0) begin
                  active[k] = 1'b1;
                  drive_port(k, 1'b1, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
               end else begin
                  drive_port(k, 1'b0, 1'b0, '0, '0);
               end
            end
         end
         tick();
      end
      drive_port(0, 1'b0, 1'b0, '0, '0);
      drive_port(1, 1'b0, 1'b0, '0, '0);
      for (int i = 0; i < 4; i++) tick();

      diffs = 0;
      for (int i = 0; i < DEPTH; i++) if (mem_env[i] !== mem_ref[i]) diffs++;
      check_eq("mem image", diffs, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
